// File: rtl/eth_phy_mdio_ctrl_if.sv
// MDIO pin and status bundle between the PHY management controller and the
// rest of the design. The master side is the controller itself.
interface eth_phy_mdio_ctrl_if;
    logic        enable;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i;
    logic        busy;
    logic        cfg_done;
    logic        link_up;
    logic        error;
    logic [15:0] phy_status;

    modport master (
        input  enable, mdio_i,
        output mdc, mdio_o, mdio_oe, busy, cfg_done, link_up, error, phy_status
    );

    modport slave (
        output enable, mdio_i,
        input  mdc, mdio_o, mdio_oe, busy, cfg_done, link_up, error, phy_status
    );
endinterface

// File: rtl/eth_phy_mdio_ctrl.sv
// Clause 22 MDIO management controller for the Pmod Ethernet PHY.
// Sequences PHY bring-up (soft reset, reset-complete wait, BMCR config) and
// then polls BMSR periodically, publishing link state and the raw status.
module eth_phy_mdio_ctrl #(
    parameter int          CLK_DIV      = 50,
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter logic [15:0] BMCR_CFG     = 16'h3100,
    parameter int          POLL_CYCLES  = 1000000,
    parameter int          RST_POLL_MAX = 255
) (
    input  logic                clk_in,
    input  logic                rst_in,
    eth_phy_mdio_ctrl_if.master bus
);
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int GAP_W  = $clog2(2 * CLK_DIV + 1);
    localparam int WAIT_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int RCNT_W = $clog2(RST_POLL_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, RST_WR, RST_POLL, CFG_WR, LINK_RD, LINK_WAIT, ERR
    } state_t;

    state_t              state, state_nxt;
    logic [RCNT_W-1:0]   rst_cnt, rst_cnt_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic                cfg_done_q, cfg_done_nxt;
    logic                link_up_q, link_up_nxt;
    logic                error_q, error_nxt;
    logic [15:0]         phy_status_q, phy_status_nxt;

    logic                mdio_meta, mdio_sync;
    logic                busy_q, mdc_q, mdo_q, mdo_en_q, rd_op;
    logic [DIV_W-1:0]    div_cnt;
    logic [5:0]          bit_idx;
    logic [63:0]         shreg;
    logic [15:0]         rdata;
    logic [GAP_W-1:0]    gap_cnt;

    logic                frame_req, frame_wr, frame_start, frame_end, div_wrap;
    logic [4:0]          frame_reg;
    logic [15:0]         frame_data;
    logic [63:0]         frame_word;

    assign div_wrap    = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign frame_end   = busy_q && div_wrap && mdc_q && (bit_idx == 6'd63);
    assign frame_start = frame_req && bus.enable && !busy_q && (gap_cnt == '0);
    // Reads leave TA and data as ones; those bits are never driven (oe low).
    assign frame_word  = {32'hFFFF_FFFF, 2'b01, frame_wr ? 2'b01 : 2'b10, PHY_ADDR,
                          frame_reg, frame_wr ? 2'b10 : 2'b11, frame_data};

    // Two-flop synchroniser for the PHY-driven MDIO line.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mdio_meta <= 1'b1;
            mdio_sync <= 1'b1;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            mdio_meta <= bus.mdio_i;
            mdio_sync <= mdio_meta;
        end
    end

    // Bit engine: MDC divider, frame shifter, oe release and read capture.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q   <= 1'b0;
            mdc_q    <= 1'b0;
            mdo_q    <= 1'b1;
            mdo_en_q <= 1'b0;
            div_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rd_op    <= 1'b0;
            rdata    <= '0;
            gap_cnt  <= '0;
        end else if (frame_start) begin
            busy_q   <= 1'b1;
            mdc_q    <= 1'b0;
            div_cnt  <= '0;
            bit_idx  <= '0;
            mdo_q    <= frame_word[63];
            shreg    <= {frame_word[62:0], 1'b1};
            mdo_en_q <= 1'b1;
            rd_op    <= !frame_wr;
        end else if (busy_q) begin
            if (!div_wrap) begin
                div_cnt <= div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
                mdc_q   <= !mdc_q;
                if (!mdc_q) begin
                    // Rising MDC: sample the data phase of a read.
                    if (bit_idx >= 6'd48) rdata <= {rdata[14:0], mdio_sync};
                end else if (bit_idx == 6'd63) begin
                    // Falling MDC after the last bit closes the frame.
                    busy_q   <= 1'b0;
                    mdo_q    <= 1'b1;
                    mdo_en_q <= 1'b0;
                    gap_cnt  <= GAP_W'(2 * CLK_DIV);
                end else begin
                    bit_idx <= bit_idx + 1'b1;
                    mdo_q   <= shreg[63];
                    shreg   <= {shreg[62:0], 1'b1};
                    if (rd_op && bit_idx >= 6'd45) mdo_en_q <= 1'b0;
                end
            end
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // Sequencer state and published status registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            rst_cnt      <= '0;
            wait_cnt     <= '0;
            cfg_done_q   <= 1'b0;
            link_up_q    <= 1'b0;
            error_q      <= 1'b0;
            phy_status_q <= '0;
        end else begin
            state        <= state_nxt;
            rst_cnt      <= rst_cnt_nxt;
            wait_cnt     <= wait_cnt_nxt;
            cfg_done_q   <= cfg_done_nxt;
            link_up_q    <= link_up_nxt;
            error_q      <= error_nxt;
            phy_status_q <= phy_status_nxt;
        end
    end

    // Sequencer next-state, frame requests and status updates.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_nxt      = state;
        rst_cnt_nxt    = rst_cnt;
        wait_cnt_nxt   = wait_cnt;
        cfg_done_nxt   = cfg_done_q;
        link_up_nxt    = link_up_q;
        error_nxt      = error_q;
        phy_status_nxt = phy_status_q;
        frame_req      = 1'b0;
        frame_wr       = 1'b0;
        frame_reg      = 5'd0;
        frame_data     = 16'hFFFF;
        unique case (state)
            IDLE: if (bus.enable) state_nxt = RST_WR;
            RST_WR: begin
                frame_req  = 1'b1;
                frame_wr   = 1'b1;
                frame_data = 16'h8000;
                if (frame_end) begin
                    rst_cnt_nxt = '0;
                    state_nxt   = RST_POLL;
                end
            end
            RST_POLL: begin
                frame_req = 1'b1;
                if (frame_end) begin
                    if (!rdata[15]) begin
                        state_nxt = CFG_WR;
                    end else begin
                        rst_cnt_nxt = rst_cnt + 1'b1;
                        if (rst_cnt_nxt == RCNT_W'(RST_POLL_MAX)) begin
                            error_nxt = 1'b1;
                            state_nxt = ERR;
                        end
                    end
                end
            end
            CFG_WR: begin
                frame_req  = 1'b1;
                frame_wr   = 1'b1;
                frame_data = BMCR_CFG;
                if (frame_end) begin
                    cfg_done_nxt = 1'b1;
                    state_nxt    = LINK_RD;
                end
            end
            LINK_RD: begin
                frame_req = 1'b1;
                frame_reg = 5'd1;
                if (frame_end) begin
                    phy_status_nxt = rdata;
                    link_up_nxt    = rdata[2];
                    wait_cnt_nxt   = '0;
                    state_nxt      = LINK_WAIT;
                end
            end
            LINK_WAIT: begin
                if (wait_cnt == WAIT_W'(POLL_CYCLES - 1)) begin
                    wait_cnt_nxt = '0;
                    state_nxt    = LINK_RD;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            ERR: begin
                error_nxt    = 1'b1;
                cfg_done_nxt = 1'b0;
                link_up_nxt  = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
        // Disable wins over any transition, but never cuts a frame short.
        if (!bus.enable && (frame_end || !busy_q)) begin
            state_nxt    = IDLE;
            rst_cnt_nxt  = '0;
            wait_cnt_nxt = '0;
            cfg_done_nxt = 1'b0;
            link_up_nxt  = 1'b0;
            error_nxt    = 1'b0;
        end
    end

    assign bus.mdc        = mdc_q;
    assign bus.mdio_o     = mdo_q;
    assign bus.mdio_oe    = mdo_en_q;
    assign bus.busy       = busy_q;
    assign bus.cfg_done   = cfg_done_q;
    assign bus.link_up    = link_up_q;
    assign bus.error      = error_q;
    assign bus.phy_status = phy_status_q;
endmodule

// File: doc/eth_phy_mdio_ctrl.md
Name: eth_phy_mdio_ctrl

Overview:
- MDIO management controller for the Pmod Ethernet PHY, clocked from clk_in.
- On enable it sequences the PHY bring-up: software reset, then a wait for the reset to complete, then a BMCR configuration write.
- After bring-up it polls BMSR periodically and publishes link state to the rest of the design.
- It contains its own bit-level MDIO (Clause 22) shifter; no external MDIO master is shared.

Parameters:
- CLK_DIV, 50: clk_in cycles per MDC half-period (100 MHz gives 1 MHz MDC); minimum 2.
- PHY_ADDR, 5'd1: PHY address field of every frame.
- BMCR_CFG, 16'h3100: value written to register 0 after reset (autoneg enabled, 100M, full duplex).
- POLL_CYCLES, 1000000: clk_in cycles between completed BMSR reads.
- RST_POLL_MAX, 255: maximum number of BMCR reads while waiting for bit 15 to clear.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 runs bring-up and polling, 0 returns to idle.
- mdc  out  1  MDIO clock to the PHY.
- mdio_o  out  1  MDIO data out.
- mdio_oe  out  1  tri-state enable for mdio_o; 1 = controller drives.
- mdio_i  in  1  MDIO data in, synchronised internally (2-flop).
- busy  out  1  an MDIO frame is in flight.
- cfg_done  out  1  bring-up sequence completed.
- link_up  out  1  BMSR bit 2 from the last successful read.
- error  out  1  reset-wait timeout; sticky.
- phy_status  out  16  last BMSR value read.

Behaviour:
- Reset (rst_in=1, asynchronous) forces all registers:
  - mdc=0, mdio_o=1, mdio_oe=0, busy=0, cfg_done=0, link_up=0, error=0, phy_status=16'h0000.
  - FSM=IDLE, all counters 0.
  - Reset asserted mid-frame aborts the frame immediately; no partial-state recovery.
- MDC generation:
  - Divider counts 0..CLK_DIV-1 only while busy; mdc toggles when it wraps.
  - mdc idles low; a frame begins with mdc low.
- Frame format: 64 bits, index 0..63, MSB first.
  - Bits 0-31: preamble, all 1.
  - Bits 32-33: ST = 01.
  - Bits 34-35: OP = 01 (write) or 10 (read).
  - Bits 36-40: PHY_ADDR. Bits 41-45: REGAD.
  - Bits 46-47: TA; 10 for writes, released for reads.
  - Bits 48-63: data.
- Bit timing:
  - mdio_o updates on the clk_in cycle in which mdc goes low.
  - mdio_i (synchronised) is sampled on the cycle in which mdc goes high.
  - Each bit lasts 2*CLK_DIV clk_in cycles; a frame lasts 128*CLK_DIV cycles.
- mdio_oe:
  - Writes: 1 for bits 0-63.
  - Reads: 1 for bits 0-45, 0 for bits 46-63.
  - Read data is the 16 samples from bits 48-63.
- Frame end and idle: after bit 63 the next falling edge ends the frame. Then mdc=0, busy=0, mdio_oe=0, mdio_o=1, and there are at least 2*CLK_DIV idle cycles before the next frame.
- FSM states and transitions:
  - IDLE: when enable=1, go to RST_WR.
  - RST_WR: write reg 0 = 16'h8000; on done, clear the poll count and go to RST_POLL.
  - RST_POLL: read reg 0.
    - If bit 15 = 0, go to CFG_WR.
    - Otherwise increment the poll count; when the count reaches RST_POLL_MAX, set error=1 and go to ERR.
  - CFG_WR: write reg 0 = BMCR_CFG; on done, set cfg_done=1 and go to LINK_RD.
  - LINK_RD: read reg 1; on done, phy_status <= data, link_up <= data[2], go to LINK_WAIT.
  - LINK_WAIT: count POLL_CYCLES cycles, then go to LINK_RD.
  - ERR: hold; error stays 1, cfg_done=0, link_up=0.
- enable deasserted:
  - While a frame is in flight, the frame completes, then the FSM goes to IDLE.
  - Otherwise the FSM goes to IDLE on the next cycle.
  - In IDLE: cfg_done=0, link_up=0, error=0, phy_status is held.
  - Re-asserting enable restarts at RST_WR.
- Simultaneous events:
  - enable falling on the frame-done cycle takes priority over the next-state transition.
  - The timeout check uses the post-increment count.

Test Plan:
- Config CLK_DIV=2, POLL_CYCLES=100, RST_POLL_MAX=4. PHY model returns BMCR=0x0000, BMSR=0x7849. Pulse enable -> captured frames in order:
  - write reg0=0x8000;
  - read reg0;
  - write reg0=0x3100;
  - read reg1.
  - Then cfg_done=1, link_up=0, phy_status=0x7849.
- PHY model changes BMSR to 0x786D -> link_up=1 within one poll interval (100 cycles + 256 cycles per frame).
- PHY holds BMCR bit 15 = 1 -> exactly 4 reg0 reads, then error=1. No CFG_WR frame, mdio_oe=0, mdc static low.
- Frame timing on a read:
  - mdc period is 4 cycles;
  - mdio_oe falls at bit 46;
  - frame length is 256 cycles;
  - bits 32-45 equal 01 10 00001 00001 (binary, for the read of reg1).
- enable dropped mid LINK_RD frame -> frame completes all 64 bits, then IDLE with cfg_done=0, link_up=0. Re-enable -> starts with the 0x8000 write.
- rst_in pulsed mid-frame (bit ~20) -> on that same cycle mdc=0, mdio_oe=0, busy=0, and all outputs take their reset values.
